icache_uncached_responder: RTL and testbench
============================================

Name: icache_uncached_responder

Overview:
- Responder (ICache-side) end of the CPU instruction-fetch request/addr_ok/data_ok handshake, built as an uncached, in-order fetch engine.
- Accepts fetch requests from the pre_IF stage and issues single-beat reads on a valid/ready memory read channel (AR/R).
- Returns instruction words in request order with a one-cycle data_ok pulse.
- Also acknowledges I-cache maintenance ops as no-ops. Serves as the bring-up replacement for the cached ICache behind the same CPU port.

Parameters:
- MAX_OUTSTANDING, 2, maximum number of accepted fetches awaiting data_ok (legal values 1..4).

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- req  in  1  CPU fetch/cache-op request
- iscache  in  1  cacheable attribute; ignored, every fetch is treated as uncached
- offset  in  4  address bits [3:0]
- index  in  8  address bits [11:4]
- tag  in  20  physical address bits [31:12]
- cachetype  in  5  CacheType {cacheCode[2:0], isIcache, isDcache}
- cache_valid, cache_tag[19:0], cache_index[7:0]  in  ignored, kept for port compatibility
- addr_ok  out  1  request accepted this cycle
- data_ok  out  1  one-cycle pulse, rdata valid
- rdata  out  32  returned instruction
- ar_valid  out  1  read address valid
- ar_ready  in  1  read address accepted
- ar_addr  out  32  {tag,index,offset[3:2],2'b00}
- r_valid  in  1  read data valid
- r_ready  out  1  read data accept
- r_data  in  32  read data

Behaviour:
- Reset (resetn low, async): addr_ok=0, data_ok=0, rdata=0, ar_valid=0, ar_addr=0, r_ready=0, outstanding count=0, AR holding register empty.
- Op classification at req: cache_op = isIcache && cacheCode!=EMPTY; otherwise the request is a fetch.
- Outstanding counter cnt (0..MAX_OUTSTANDING) counts accepted fetches not yet returned via data_ok. Cache ops never count.
- addr_ok (combinational) = req && cnt<MAX_OUTSTANDING && (AR holding empty || (ar_valid && ar_ready)).
- Cache ops: same addr_ok gating. Fire-and-forget: no memory read and no data_ok.
- Fetch accept (req && addr_ok && !cache_op):
  - Address is loaded into the AR holding register; ar_valid=1 from the next cycle.
  - ar_addr is held stable until ar_ready.
  - Address bits [1:0] are forced to 0.
- AR FSM states:
  - IDLE --accept--> ISSUE.
  - ISSUE --ar_ready && !accept--> IDLE.
  - ISSUE --ar_ready && accept--> ISSUE (back-to-back, new address).
  - ar_valid is never withdrawn before ar_ready.
- R channel:
  - r_ready=1 whenever cnt>0 and out of reset.
  - On r_valid && r_ready: rdata<=r_data, data_ok<=1 in the next cycle; otherwise data_ok<=0.
  - Minimum latency from addr_ok to data_ok is 3 cycles (accept, AR handshake with ar_ready=1, R handshake with r_valid, data_ok).
- cnt update: +1 on fetch accept, -1 on R handshake. Simultaneous accept and return leaves cnt unchanged.
- Ordering: responses are strictly in acceptance order; the memory channel is required to be in-order.
- Boundaries:
  - cnt==MAX_OUTSTANDING: addr_ok=0 even if a return occurs in the same cycle (no combinational path from r_valid to addr_ok).
  - r_valid while cnt==0 is a protocol error. r_ready=0 in that state, so the beat is not consumed.
  - req deasserted mid-flight has no effect on outstanding fetches.
  - resetn assertion mid-operation drops all in-flight state immediately. Late R beats after reset release are the memory model's responsibility; the bench must not generate them.
- rdata holds its last value when data_ok=0.

Decomposition:
- Shared CPU package holds:
  - CacheCodeType and CacheType (already shared).
  - A new constant ICACHE_MAX_OUTSTANDING.
  - An optional packed struct mem_rd_req_t {valid, addr}.
- One natural sub-module, icache_ar_slot: the single-entry AR holding register with the valid/ready hold rule.
- Counter, classification and R return logic stay in the top module.

Test Plan:
1. Single fetch at 0xBFC00004, ar_ready=1, r_valid one cycle after AR with r_data=0x3C08BFC0 -> ar_addr=0xBFC00004; data_ok pulses exactly once, 3 cycles after addr_ok, rdata=0x3C08BFC0.
2. Back-to-back fetches 0x1000, 0x1004, 0x1008 with MAX_OUTSTANDING=2 and r_valid held low -> the first two get addr_ok, the third stalls (addr_ok=0). After the first R beat the third is accepted. data_ok order matches 0x1000, 0x1004, 0x1008 data.
3. ar_ready held low 5 cycles -> ar_valid stays 1 with ar_addr constant; no new addr_ok is granted while the holding register is full.
4. Cache op with cachetype={I_Hit_Invalid,1,0} -> addr_ok=1, no ar_valid, no data_ok, cnt unchanged. A following fetch proceeds normally.
5. Simultaneous accept and R return at cnt=1 -> cnt remains 1; the returned data is for the older request.
6. Async resetn pulse with 2 fetches outstanding -> all outputs 0 within the same cycle, cnt=0. After release, a fresh fetch completes normally.

Source files
------------

// File: rtl/icache_uncached_responder_pkg.sv
// Shared CPU-side types for the instruction-fetch port and the uncached
// fetch engine that answers it during bring-up.
package icache_uncached_responder_pkg;

    localparam int ICACHE_MAX_OUTSTANDING = 2;

    typedef enum logic [2:0] {
        EMPTY                     = 3'd0,
        I_Index_Invalid           = 3'd1,
        I_Index_Store_Tag         = 3'd2,
        I_Hit_Invalid             = 3'd3,
        D_Index_Writeback_Invalid = 3'd4,
        D_Index_Store_Tag         = 3'd5,
        D_Hit_Invalid             = 3'd6,
        D_Hit_Writeback_Invalid   = 3'd7
    } CacheCodeType;

    typedef struct packed {
        CacheCodeType cacheCode;
        logic         isIcache;
        logic         isDcache;
    } CacheType;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
    } mem_rd_req_t;

    typedef enum logic {
        AR_IDLE,
        AR_ISSUE
    } ar_state_t;

    // Fetches are always word aligned, so the byte offset is dropped.
    function automatic logic [31:0] fetch_addr(input logic [19:0] tag,
                                               input logic [7:0]  index,
                                               input logic [1:0]  word);
        return {tag, index, word, 2'b00};
    endfunction

endpackage

// File: rtl/icache_uncached_responder_if.sv
// CPU fetch port plus the AR/R memory read channel of the uncached responder.
interface icache_uncached_responder_if;

    logic        req;
    logic        iscache;
    logic [3:0]  offset;
    logic [7:0]  index;
    logic [19:0] tag;
    logic [4:0]  cachetype;
    logic        cache_valid;
    logic [19:0] cache_tag;
    logic [7:0]  cache_index;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    logic        ar_valid;
    logic        ar_ready;
    logic [31:0] ar_addr;
    logic        r_valid;
    logic        r_ready;
    logic [31:0] r_data;

    modport master (
        output req, iscache, offset, index, tag, cachetype,
               cache_valid, cache_tag, cache_index,
               ar_ready, r_valid, r_data,
        input  addr_ok, data_ok, rdata, ar_valid, ar_addr, r_ready
    );

    modport slave (
        input  req, iscache, offset, index, tag, cachetype,
               cache_valid, cache_tag, cache_index,
               ar_ready, r_valid, r_data,
        output addr_ok, data_ok, rdata, ar_valid, ar_addr, r_ready
    );

endinterface

// File: rtl/icache_ar_slot.sv
// Single-entry read-address holding register; ar_valid is never dropped
// before ar_ready, and a new address may replace the old one on the handshake.
module icache_ar_slot
    import icache_uncached_responder_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  mem_rd_req_t load,
    input  logic        ar_ready,
    output logic        ar_valid,
    output logic [31:0] ar_addr,
    output logic        slot_free
);

    ar_state_t state;

    assign slot_free = !ar_valid || ar_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= AR_IDLE;
            ar_valid <= 1'b0;
            ar_addr  <= '0;
        end else begin
            case (state)
                AR_IDLE: begin
                    if (load.valid) begin
                        state    <= AR_ISSUE;
                        ar_valid <= 1'b1;
                        ar_addr  <= load.addr;
                    end
                end
                AR_ISSUE: begin
                    if (ar_ready) begin
                        if (load.valid) begin
                            ar_addr <= load.addr;
                        end else begin
                            state    <= AR_IDLE;
                            ar_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    state    <= AR_IDLE;
                    ar_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/icache_uncached_responder.sv
// Uncached, in-order instruction fetch engine behind the ICache CPU port;
// I-cache maintenance ops are acknowledged and otherwise ignored.
module icache_uncached_responder
    import icache_uncached_responder_pkg::*;
#(
    parameter int MAX_OUTSTANDING = ICACHE_MAX_OUTSTANDING
) (
    input  logic                         clk,
    input  logic                         resetn,
    icache_uncached_responder_if.slave   bus
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    CacheType          op_type;
    logic              is_cache_op;
    logic              addr_ok_c;
    logic              fetch_accept;
    logic              r_fire;
    logic              slot_free;
    logic [CNT_W-1:0]  cnt;
    mem_rd_req_t       ar_load;

    assign op_type     = bus.cachetype;
    assign is_cache_op = op_type.isIcache && (op_type.cacheCode != EMPTY);

    // The full-count check uses only the registered count, so a same-cycle
    // return cannot open the gate combinationally.
    assign addr_ok_c    = resetn && bus.req && (cnt < MAX_CNT) && slot_free;
    assign fetch_accept = addr_ok_c && !is_cache_op;
    assign bus.addr_ok  = addr_ok_c;

    assign bus.r_ready = (cnt != '0);
    assign r_fire      = bus.r_valid && bus.r_ready;

    assign ar_load.valid = fetch_accept;
    assign ar_load.addr  = fetch_addr(bus.tag, bus.index, bus.offset[3:2]);

    icache_ar_slot u_ar_slot (
        .clk       (clk),
        .resetn    (resetn),
        .load      (ar_load),
        .ar_ready  (bus.ar_ready),
        .ar_valid  (bus.ar_valid),
        .ar_addr   (bus.ar_addr),
        .slot_free (slot_free)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (fetch_accept && !r_fire) begin
            cnt <= cnt + CNT_W'(1);
        end else if (!fetch_accept && r_fire) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus.data_ok <= 1'b0;
            bus.rdata   <= '0;
        end else begin
            bus.data_ok <= r_fire;
            if (r_fire) begin
                bus.rdata <= bus.r_data;
            end
        end
    end

    logic unused_inputs;
    assign unused_inputs = ^{bus.iscache, bus.cache_valid, bus.cache_tag,
                             bus.cache_index, bus.offset[1:0], op_type.isDcache};

endmodule

// File: tb/tb_icache_uncached_responder.sv
// Directed bench for the uncached ICache responder: fetch latency, ordering,
// outstanding limit, AR back-pressure, cache ops and asynchronous reset.
module tb_icache_uncached_responder;

    logic clk;
    logic resetn;
    int   checks;
    int   errors;

    icache_uncached_responder_if bus();

    icache_uncached_responder #(.MAX_OUTSTANDING(2)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fetch(input logic [31:0] a);
        bus.req       = 1'b1;
        bus.tag       = a[31:12];
        bus.index     = a[11:4];
        bus.offset    = a[3:0];
        bus.cachetype = 5'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        #3;
        checks++; if (bus.addr_ok !== 1'b0) begin errors++; $display("[TB] FAIL reset_addr_ok got %h expected %h", bus.addr_ok, 1'b0); end
        checks++; if (bus.data_ok !== 1'b0) begin errors++; $display("[TB] FAIL reset_data_ok got %h expected %h", bus.data_ok, 1'b0); end
        checks++; if (bus.rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdata got %h expected %h", bus.rdata, 32'h0); end
        checks++; if (bus.ar_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_ar_valid got %h expected %h", bus.ar_valid, 1'b0); end
        checks++; if (bus.ar_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_ar_addr got %h expected %h", bus.ar_addr, 32'h0); end
        checks++; if (bus.r_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_r_ready got %h expected %h", bus.r_ready, 1'b0); end
        set_fetch(32'h0000_0040);
        #1;
        checks++; if (bus.addr_ok !== 1'b0) begin errors++; $display("[TB] FAIL reset_addr_ok_req got %h expected %h", bus.addr_ok, 1'b0); end
        bus.req = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_single_fetch();
        bus.ar_ready = 1'b1;
        set_fetch(32'hBFC0_0004);
        #1;
        checks++; if (bus.addr_ok !== 1'b1) begin errors++; $display("[TB] FAIL single_addr_ok got %h expected %h", bus.addr_ok, 1'b1); end
        tick();
        bus.req = 1'b0;
        #1;
        checks++; if (bus.ar_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_ar_valid got %h expected %h", bus.ar_valid, 1'b1); end
        checks++; if (bus.ar_addr !== 32'hBFC0_0004) begin errors++; $display("[TB] FAIL single_ar_addr got %h expected %h", bus.ar_addr, 32'hBFC0_0004); end
        checks++; if (bus.data_ok !== 1'b0) begin errors++; $display("[TB] FAIL single_data_ok_c1 got %h expected %h", bus.data_ok, 1'b0); end
        checks++; if (bus.r_ready !== 1'b1) begin errors++; $display("[TB] FAIL single_r_ready got %h expected %h", bus.r_ready, 1'b1); end
        tick();
        bus.r_valid = 1'b1;
        bus.r_data  = 32'h3C08_BFC0;
        #1;
        checks++; if (bus.ar_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_ar_drop got %h expected %h", bus.ar_valid, 1'b0); end
        checks++; if (bus.data_ok !== 1'b0) begin errors++; $display("[TB] FAIL single_data_ok_c2 got %h expected %h", bus.data_ok, 1'b0); end
        tick();
        bus.r_valid = 1'b0;
        #1;
        checks++; if (bus.data_ok !== 1'b1) begin errors++; $display("[TB] FAIL single_data_ok_c3 got %h expected %h", bus.data_ok, 1'b1); end
        checks++; if (bus.rdata !== 32'h3C08_BFC0) begin errors++; $display("[TB] FAIL single_rdata got %h expected %h", bus.rdata, 32'h3C08_BFC0); end
        tick();
        #1;
        checks++; if (bus.data_ok !== 1'b0) begin errors++; $display("[TB] FAIL single_data_ok_c4 got %h expected %h", bus.data_ok, 1'b0); end
        checks++; if (bus.rdata !== 32'h3C08_BFC0) begin errors++; $display("[TB] FAIL single_rdata_hold got %h expected %h", bus.rdata, 32'h3C08_BFC0); end
        checks++; if (bus.r_ready !== 1'b0) begin errors++; $display("[TB] FAIL single_r_ready_idle got %h expected %h", bus.r_ready, 1'b0); end
    endtask

    task automatic test_back_to_back();
        bus.ar_ready = 1'b1;
        set_fetch(32'h0000_1000);
        #1;
        checks++; if (bus.addr_ok !== 1'b1) begin errors++; $display("[TB] FAIL b2b_addr_ok0 got %h expected %h", bus.addr_ok, 1'b1); end
        tick();
        set_fetch(32'h0000_1004);
        #1;
        checks++; if (bus.addr_ok !== 1'b1) begin errors++; $display("[TB] FAIL b2b_addr_ok1 got %h expected %h", bus.addr_ok, 1'b1); end
        checks++; if (bus.ar_addr !== 32'h0000_1000) begin errors++; $display("[TB] FAIL b2b_ar_addr0 got %h expected %h", bus.ar_addr, 32'h0000_1000); end
        tick();
        // Count is full; the return in this same cycle must not open addr_ok.
        set_fetch(32'h0000_1008);
        bus.r_valid = 1'b1;
        bus.r_data  = 32'hA000_1000;
        #1;
        checks++; if (bus.addr_ok !== 1'b0) begin errors++; $display("[TB] FAIL b2b_addr_ok_full got %h expected %h", bus.addr_ok, 1'b0); end
        checks++; if (bus.ar_addr !== 32'h0000_1004) begin errors++; $display("[TB] FAIL b2b_ar_addr1 got %h expected %h", bus.ar_addr, 32'h0000_1004); end
        checks++; if (bus.ar_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ar_valid1 got %h expected %h", bus.ar_valid, 1'b1); end
        tick();
        bus.r_valid = 1'b0;
        #1;
        checks++; if (bus.data_ok !== 1'b1) begin errors++; $display("[TB] FAIL b2b_data_ok0 got %h expected %h", bus.data_ok, 1'b1); end
        checks++; if (bus.rdata !== 32'hA000_1000) begin errors++; $display("[TB] FAIL b2b_rdata0 got %h expected %h", bus.rdata, 32'hA000_1000); end
        checks++; if (bus.addr_ok !== 1'b1) begin errors++; $display("[TB] FAIL b2b_addr_ok2 got %h expected %h", bus.addr_ok, 1'b1); end
        tick();
        bus.req     = 1'b0;
        bus.r_valid = 1'b1;
        bus.r_data  = 32'hA000_1004;
        #1;
        checks++; if (bus.data_ok !== 1'b0) begin errors++; $display("[TB] FAIL b2b_data_ok_gap got %h expected %h", bus.data_ok, 1'b0); end
        checks++; if (bus.ar_addr !== 32'h0000_1008) begin errors++; $display("[TB] FAIL b2b_ar_addr2 got %h expected %h", bus.ar_addr, 32'h0000_1008); end
        tick();
        bus.r_valid = 1'b1;
        bus.r_data  = 32'hA000_1008;
        #1;
        checks++; if (bus.data_ok !== 1'b1) begin errors++; $display("[TB] FAIL b2b_data_ok1 got %h expected %h", bus.data_ok, 1'b1); end
        checks++; if (bus.rdata !== 32'hA000_1004) begin errors++; $display("[TB] FAIL b2b_rdata1 got %h expected %h", bus.rdata, 32'hA000_1004); end
        tick();
        bus.r_valid = 1'b0;
        #1;
        checks++; if (bus.data_ok !== 1'b1) begin errors++; $display("[TB] FAIL b2b_data_ok2 got %h expected %h", bus.data_ok, 1'b1); end
        checks++; if (bus.rdata !== 32'hA000_1008) begin errors++; $display("[TB] FAIL b2b_rdata2 got %h expected %h", bus.rdata, 32'hA000_1008); end
        checks++; if (bus.r_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_r_ready_idle got %h expected %h", bus.r_ready, 1'b0); end
        tick();
    endtask

    task automatic test_ar_stall();
        bus.ar_ready = 1'b0;
        set_fetch(32'h0000_2000);
        #1;
        checks++; if (bus.addr_ok !== 1'b1) begin errors++; $display("[TB] FAIL stall_addr_ok0 got %h expected %h", bus.addr_ok, 1'b1); end
        tick();
        for (int i = 0; i < 5; i++) begin
            set_fetch(32'h0000_2004);
            #1;
            checks++; if (bus.ar_valid !== 1'b1) begin errors++; $display("[TB] FAIL stall_ar_valid[%0d] got %h expected %h", i, bus.ar_valid, 1'b1); end
            checks++; if (bus.ar_addr !== 32'h0000_2000) begin errors++; $display("[TB] FAIL stall_ar_addr[%0d] got %h expected %h", i, bus.ar_addr, 32'h0000_2000); end
            checks++; if (bus.addr_ok !== 1'b0) begin errors++; $display("[TB] FAIL stall_addr_ok[%0d] got %h expected %h", i, bus.addr_ok, 1'b0); end
            tick();
        end
        bus.ar_ready = 1'b1;
        #1;
        checks++; if (bus.addr_ok !== 1'b1) begin errors++; $display("[TB] FAIL stall_addr_ok_release got %h expected %h", bus.addr_ok, 1'b1); end
        tick();
        bus.req = 1'b0;
        #1;
        checks++; if (bus.ar_addr !== 32'h0000_2004) begin errors++; $display("[TB] FAIL stall_ar_addr_next got %h expected %h", bus.ar_addr, 32'h0000_2004); end
        tick();
        bus.r_valid = 1'b1;
        bus.r_data  = 32'hE000_2000;
        #1;
        checks++; if (bus.ar_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_ar_drop got %h expected %h", bus.ar_valid, 1'b0); end
        tick();
        bus.r_data = 32'hE000_2004;
        #1;
        checks++; if (bus.rdata !== 32'hE000_2000) begin errors++; $display("[TB] FAIL stall_rdata0 got %h expected %h", bus.rdata, 32'hE000_2000); end
        tick();
        bus.r_valid = 1'b0;
        #1;
        checks++; if (bus.rdata !== 32'hE000_2004) begin errors++; $display("[TB] FAIL stall_rdata1 got %h expected %h", bus.rdata, 32'hE000_2004); end
        tick();
    endtask

    task automatic test_cache_op();
        bus.ar_ready  = 1'b1;
        set_fetch(32'h0000_7000);
        bus.cachetype = 5'b011_1_0;
        #1;
        checks++; if (bus.addr_ok !== 1'b1) begin errors++; $display("[TB] FAIL cop_addr_ok got %h expected %h", bus.addr_ok, 1'b1); end
        tick();
        bus.req       = 1'b0;
        bus.cachetype = 5'b0;
        #1;
        checks++; if (bus.ar_valid !== 1'b0) begin errors++; $display("[TB] FAIL cop_ar_valid got %h expected %h", bus.ar_valid, 1'b0); end
        checks++; if (bus.r_ready !== 1'b0) begin errors++; $display("[TB] FAIL cop_cnt_unchanged got %h expected %h", bus.r_ready, 1'b0); end
        tick();
        checks++; if (bus.data_ok !== 1'b0) begin errors++; $display("[TB] FAIL cop_data_ok got %h expected %h", bus.data_ok, 1'b0); end
        set_fetch(32'h0000_3000);
        #1;
        checks++; if (bus.addr_ok !== 1'b1) begin errors++; $display("[TB] FAIL cop_fetch_addr_ok got %h expected %h", bus.addr_ok, 1'b1); end
        tick();
        bus.req = 1'b0;
        #1;
        checks++; if (bus.ar_addr !== 32'h0000_3000) begin errors++; $display("[TB] FAIL cop_fetch_ar_addr got %h expected %h", bus.ar_addr, 32'h0000_3000); end
        tick();
        bus.r_valid = 1'b1;
        bus.r_data  = 32'h2408_0001;
        tick();
        bus.r_valid = 1'b0;
        #1;
        checks++; if (bus.data_ok !== 1'b1) begin errors++; $display("[TB] FAIL cop_fetch_data_ok got %h expected %h", bus.data_ok, 1'b1); end
        checks++; if (bus.rdata !== 32'h2408_0001) begin errors++; $display("[TB] FAIL cop_fetch_rdata got %h expected %h", bus.rdata, 32'h2408_0001); end
        tick();
    endtask

    task automatic test_simultaneous();
        bus.ar_ready = 1'b1;
        set_fetch(32'h0000_4000);
        #1;
        checks++; if (bus.addr_ok !== 1'b1) begin errors++; $display("[TB] FAIL sim_addr_ok0 got %h expected %h", bus.addr_ok, 1'b1); end
        tick();
        bus.req = 1'b0;
        tick();
        set_fetch(32'h0000_4004);
        bus.r_valid = 1'b1;
        bus.r_data  = 32'hC000_4000;
        #1;
        checks++; if (bus.addr_ok !== 1'b1) begin errors++; $display("[TB] FAIL sim_addr_ok1 got %h expected %h", bus.addr_ok, 1'b1); end
        tick();
        bus.req     = 1'b0;
        bus.r_valid = 1'b0;
        #1;
        checks++; if (bus.rdata !== 32'hC000_4000) begin errors++; $display("[TB] FAIL sim_rdata_older got %h expected %h", bus.rdata, 32'hC000_4000); end
        checks++; if (bus.r_ready !== 1'b1) begin errors++; $display("[TB] FAIL sim_cnt_one got %h expected %h", bus.r_ready, 1'b1); end
        checks++; if (bus.ar_addr !== 32'h0000_4004) begin errors++; $display("[TB] FAIL sim_ar_addr got %h expected %h", bus.ar_addr, 32'h0000_4004); end
        tick();
        bus.r_valid = 1'b1;
        bus.r_data  = 32'hC000_4004;
        tick();
        bus.r_valid = 1'b0;
        #1;
        checks++; if (bus.rdata !== 32'hC000_4004) begin errors++; $display("[TB] FAIL sim_rdata_newer got %h expected %h", bus.rdata, 32'hC000_4004); end
        checks++; if (bus.r_ready !== 1'b0) begin errors++; $display("[TB] FAIL sim_cnt_zero got %h expected %h", bus.r_ready, 1'b0); end
        tick();
    endtask

    task automatic test_reset_midflight();
        bus.ar_ready = 1'b1;
        set_fetch(32'h0000_5000);
        tick();
        set_fetch(32'h0000_5004);
        #1;
        checks++; if (bus.addr_ok !== 1'b1) begin errors++; $display("[TB] FAIL rst_addr_ok1 got %h expected %h", bus.addr_ok, 1'b1); end
        tick();
        bus.req      = 1'b0;
        bus.ar_ready = 1'b0;
        #1;
        checks++; if (bus.ar_valid !== 1'b1) begin errors++; $display("[TB] FAIL rst_pre_ar_valid got %h expected %h", bus.ar_valid, 1'b1); end
        #2;
        resetn  = 1'b0;
        bus.req = 1'b1;
        #1;
        checks++; if (bus.addr_ok !== 1'b0) begin errors++; $display("[TB] FAIL rst_addr_ok got %h expected %h", bus.addr_ok, 1'b0); end
        checks++; if (bus.ar_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_ar_valid got %h expected %h", bus.ar_valid, 1'b0); end
        checks++; if (bus.ar_addr !== 32'h0) begin errors++; $display("[TB] FAIL rst_ar_addr got %h expected %h", bus.ar_addr, 32'h0); end
        checks++; if (bus.rdata !== 32'h0) begin errors++; $display("[TB] FAIL rst_rdata got %h expected %h", bus.rdata, 32'h0); end
        checks++; if (bus.r_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_r_ready got %h expected %h", bus.r_ready, 1'b0); end
        checks++; if (bus.data_ok !== 1'b0) begin errors++; $display("[TB] FAIL rst_data_ok got %h expected %h", bus.data_ok, 1'b0); end
        tick();
        bus.req = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        tick();
        bus.ar_ready = 1'b1;
        set_fetch(32'h0000_6000);
        #1;
        checks++; if (bus.r_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_cnt_cleared got %h expected %h", bus.r_ready, 1'b0); end
        checks++; if (bus.addr_ok !== 1'b1) begin errors++; $display("[TB] FAIL rst_fresh_addr_ok got %h expected %h", bus.addr_ok, 1'b1); end
        tick();
        bus.req = 1'b0;
        #1;
        checks++; if (bus.ar_addr !== 32'h0000_6000) begin errors++; $display("[TB] FAIL rst_fresh_ar_addr got %h expected %h", bus.ar_addr, 32'h0000_6000); end
        tick();
        bus.r_valid = 1'b1;
        bus.r_data  = 32'h0000_6A6A;
        tick();
        bus.r_valid = 1'b0;
        #1;
        checks++; if (bus.data_ok !== 1'b1) begin errors++; $display("[TB] FAIL rst_fresh_data_ok got %h expected %h", bus.data_ok, 1'b1); end
        checks++; if (bus.rdata !== 32'h0000_6A6A) begin errors++; $display("[TB] FAIL rst_fresh_rdata got %h expected %h", bus.rdata, 32'h0000_6A6A); end
        tick();
        checks++; if (bus.data_ok !== 1'b0) begin errors++; $display("[TB] FAIL rst_fresh_data_ok_end got %h expected %h", bus.data_ok, 1'b0); end
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        resetn          = 1'b0;
        bus.req         = 1'b0;
        bus.iscache     = 1'b0;
        bus.offset      = '0;
        bus.index       = '0;
        bus.tag         = '0;
        bus.cachetype   = '0;
        bus.cache_valid = 1'b0;
        bus.cache_tag   = '0;
        bus.cache_index = '0;
        bus.ar_ready    = 1'b0;
        bus.r_valid     = 1'b0;
        bus.r_data      = '0;

        test_reset();
        $display("[TB] single fetch");
        test_single_fetch();
        $display("[TB] back to back");
        test_back_to_back();
        $display("[TB] AR stall");
        test_ar_stall();
        $display("[TB] cache op");
        test_cache_op();
        $display("[TB] simultaneous accept and return");
        test_simultaneous();
        $display("[TB] reset mid-flight");
        test_reset_midflight();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
